// File: rtl/ir_nec_transmitter_pkg.sv
// ---------------------------------------------------------------------------
// ir_nec_transmitter_pkg
// Shared NEC IR protocol definitions, intended for both the transmit and the
// receive side of the link:
//   - nec_state_e   : frame sequencer state encodings
//   - *_UNITS       : duration of each frame element in NEC units (562.5 us)
//   - FRAME_UNITS_DEFAULT : start-to-start frame period (108 ms)
//   - helper functions for mark detection, per-state unit terminal counts
//     and assembly of the 32-bit on-air word
// ---------------------------------------------------------------------------
package ir_nec_transmitter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_LEAD_MARK  = 3'd1,
      ST_LEAD_SPACE = 3'd2,
      ST_REP_SPACE  = 3'd3,
      ST_BIT_MARK   = 3'd4,
      ST_BIT_SPACE  = 3'd5,
      ST_STOP_MARK  = 3'd6,
      ST_GAP        = 3'd7
   } nec_state_e;

   localparam int LEAD_MARK_UNITS     = 16;
   localparam int LEAD_SPACE_UNITS    = 8;
   localparam int REP_SPACE_UNITS     = 4;
   localparam int BIT_MARK_UNITS      = 1;
   localparam int BIT0_SPACE_UNITS    = 1;
   localparam int BIT1_SPACE_UNITS    = 3;
   localparam int STOP_UNITS          = 1;
   localparam int FRAME_UNITS_DEFAULT = 192;
   localparam int WORD_BITS           = 32;

   // States during which the IR LED is lit (envelope high).
   function automatic logic is_mark(input nec_state_e s);
      return (s == ST_LEAD_MARK) || (s == ST_BIT_MARK) || (s == ST_STOP_MARK);
   endfunction

   // Last unit index (duration - 1) of a timed state. The bit space length
   // depends on the bit currently at the head of the shift register.
   function automatic logic [4:0] last_unit(input nec_state_e s, input logic bit_val);
      logic [4:0] n;
      n = 5'd1;
      case (s)
         ST_LEAD_MARK:  n = 5'(LEAD_MARK_UNITS);
         ST_LEAD_SPACE: n = 5'(LEAD_SPACE_UNITS);
         ST_REP_SPACE:  n = 5'(REP_SPACE_UNITS);
         ST_BIT_MARK:   n = 5'(BIT_MARK_UNITS);
         ST_BIT_SPACE:  n = bit_val ? 5'(BIT1_SPACE_UNITS) : 5'(BIT0_SPACE_UNITS);
         ST_STOP_MARK:  n = 5'(STOP_UNITS);
         default:       n = 5'd1;
      endcase
      return n - 5'd1;
   endfunction

   // On-air word, transmitted LSB first: address, ~address, command, ~command.
   function automatic logic [WORD_BITS-1:0] nec_word(input logic [7:0] addr,
                                                     input logic [7:0] cmd);
      return {~cmd, cmd, ~addr, addr};
   endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// ---------------------------------------------------------------------------
// ir_carrier_gen
// Free-running IR carrier (~38 kHz, ~1/3 duty) with a synchronous phase
// restart so every mark burst starts on a fresh high phase.
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   restart  in  force phase 0 on the next clock (asserted on mark entry)
//   carrier  out registered carrier, high while phase < CARRIER_HIGH
// ---------------------------------------------------------------------------
module ir_carrier_gen #(
   parameter int CARRIER_DIV  = 1316,
   parameter int CARRIER_HIGH = 439
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic carrier
);

   localparam int PW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
   localparam logic [PW-1:0] PHASE_LAST = PW'(CARRIER_DIV - 1);
   localparam logic [PW-1:0] PHASE_HIGH = PW'(CARRIER_HIGH);

   logic [PW-1:0] phase_q, phase_d;
   logic          carrier_q, carrier_d;

   always_comb begin
      phase_d = phase_q + 1'b1;
      if (restart || (phase_q == PHASE_LAST)) begin
         phase_d = '0;
      end
      // Carrier is registered from the next phase so it lines up with the
      // registered envelope in the top level.
      carrier_d = (phase_d < PHASE_HIGH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q   <= '0;
         carrier_q <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         carrier_q <= carrier_d;
      end
   end

   assign carrier = carrier_q;

endmodule

// File: rtl/ir_nec_transmitter.sv
// ---------------------------------------------------------------------------
// ir_nec_transmitter
// NEC-protocol IR transmitter. Serialises an 8-bit address and command into
// a standard NEC data frame, or sends a repeat frame, then holds busy until
// the 108 ms start-to-start frame period has elapsed.
// Ports:
//   clk          in   system clock (50 MHz)
//   rst_n        in   asynchronous active-low reset, aborts any frame
//   tx_start     in   request a data frame (wins over tx_repeat), idle only
//   tx_repeat    in   request a repeat frame, idle only
//   tx_addr[7:0] in   address byte, latched on accept
//   tx_cmd[7:0]  in   command byte, latched on accept
//   tx_busy      out  high from the cycle after accept to the end of period
//   tx_done      out  one-cycle pulse at the end of the frame period
//   ir_envelope  out  unmodulated mark (1) / space (0)
//   ir_tx_out    out  envelope gated by the carrier, drives the IR LED
// ---------------------------------------------------------------------------
module ir_nec_transmitter
   import ir_nec_transmitter_pkg::*;
#(
   parameter int UNIT_CYC     = 28125,
   parameter int CARRIER_DIV  = 1316,
   parameter int CARRIER_HIGH = 439,
   parameter int FRAME_UNITS  = FRAME_UNITS_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_start,
   input  logic       tx_repeat,
   input  logic [7:0] tx_addr,
   input  logic [7:0] tx_cmd,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       ir_envelope,
   output logic       ir_tx_out
);

   localparam int UCW = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
   localparam int FCW = $clog2(FRAME_UNITS * UNIT_CYC);
   localparam logic [UCW-1:0] UNIT_LAST  = UCW'(UNIT_CYC - 1);
   localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_UNITS * UNIT_CYC - 1);

   nec_state_e           state_q, state_d;
   logic [UCW-1:0]       unit_cyc_q, unit_cyc_d;
   logic [4:0]           unit_cnt_q, unit_cnt_d;
   logic [FCW-1:0]       frame_cnt_q, frame_cnt_d;
   logic [4:0]           bit_cnt_q, bit_cnt_d;
   logic [WORD_BITS-1:0] shift_q, shift_d;
   logic                 repeat_q, repeat_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;
   logic                 envelope_q, envelope_d;

   logic                 phase_end;
   logic                 carrier_restart;
   logic                 carrier;

   // ---------------------------------------------------------------------
   // Next-state / datapath
   // ---------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      unit_cyc_d  = unit_cyc_q;
      unit_cnt_d  = unit_cnt_q;
      frame_cnt_d = frame_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      repeat_d    = repeat_q;
      done_d      = 1'b0;

      // The current timed state is in its very last clock.
      phase_end = (unit_cyc_q == UNIT_LAST) &&
                  (unit_cnt_q == last_unit(state_q, shift_q[0]));

      // Frame period counter runs for the whole busy window, LEAD_MARK to GAP.
      if (state_q != ST_IDLE) begin
         frame_cnt_d = frame_cnt_q + 1'b1;
      end

      // Unit timer only matters in the timed states; it is cleared on every
      // state change below.
      if ((state_q != ST_IDLE) && (state_q != ST_GAP)) begin
         if (unit_cyc_q == UNIT_LAST) begin
            unit_cyc_d = '0;
            unit_cnt_d = unit_cnt_q + 5'd1;
         end else begin
            unit_cyc_d = unit_cyc_q + 1'b1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (tx_start) begin
               state_d     = ST_LEAD_MARK;
               shift_d     = nec_word(tx_addr, tx_cmd);
               repeat_d    = 1'b0;
               bit_cnt_d   = '0;
               frame_cnt_d = '0;
            end else if (tx_repeat) begin
               state_d     = ST_LEAD_MARK;
               repeat_d    = 1'b1;
               bit_cnt_d   = '0;
               frame_cnt_d = '0;
            end
         end
         ST_LEAD_MARK: begin
            if (phase_end) begin
               state_d = repeat_q ? ST_REP_SPACE : ST_LEAD_SPACE;
            end
         end
         ST_LEAD_SPACE: begin
            if (phase_end) begin
               state_d = ST_BIT_MARK;
            end
         end
         ST_REP_SPACE: begin
            if (phase_end) begin
               state_d = ST_STOP_MARK;
            end
         end
         ST_BIT_MARK: begin
            if (phase_end) begin
               state_d = ST_BIT_SPACE;
            end
         end
         ST_BIT_SPACE: begin
            if (phase_end) begin
               shift_d   = shift_q >> 1;
               bit_cnt_d = bit_cnt_q + 5'd1;
               state_d   = (bit_cnt_q == 5'd31) ? ST_STOP_MARK : ST_BIT_MARK;
            end
         end
         ST_STOP_MARK: begin
            if (phase_end) begin
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (frame_cnt_q == FRAME_LAST) begin
               state_d     = ST_IDLE;
               done_d      = 1'b1;
               frame_cnt_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (state_d != state_q) begin
         unit_cyc_d = '0;
         unit_cnt_d = '0;
      end

      // Outputs are registered from the next state so they change exactly
      // with the state and carry no decode glitches to the LED driver.
      busy_d     = (state_d != ST_IDLE);
      envelope_d = is_mark(state_d);

      // Every mark is entered from a non-mark state, so this fires once per
      // burst and the burst begins on the carrier high phase.
      carrier_restart = is_mark(state_d) && !is_mark(state_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         unit_cyc_q  <= '0;
         unit_cnt_q  <= '0;
         frame_cnt_q <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         repeat_q    <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         envelope_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         unit_cyc_q  <= unit_cyc_d;
         unit_cnt_q  <= unit_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         repeat_q    <= repeat_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         envelope_q  <= envelope_d;
      end
   end

   ir_carrier_gen #(
      .CARRIER_DIV  (CARRIER_DIV),
      .CARRIER_HIGH (CARRIER_HIGH)
   ) u_carrier (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (carrier_restart),
      .carrier (carrier)
   );

   assign tx_busy     = busy_q;
   assign tx_done     = done_q;
   assign ir_envelope = envelope_q;
   assign ir_tx_out   = envelope_q & carrier;

endmodule

// File: tb/tb_ir_nec_transmitter.sv
// ---------------------------------------------------------------------------
// tb_ir_nec_transmitter
// Directed bench for the NEC transmitter with sim timing (UNIT_CYC=10,
// CARRIER_DIV=6, CARRIER_HIGH=2). Each frame is recorded one sample per
// cycle from the cycle after accept, then decoded by run length.
// ---------------------------------------------------------------------------
module tb_ir_nec_transmitter;

   localparam int MAXS = 2400;

   logic       clk;
   logic       rst_n;
   logic       tx_start;
   logic       tx_repeat;
   logic [7:0] tx_addr;
   logic [7:0] tx_cmd;
   logic       tx_busy;
   logic       tx_done;
   logic       ir_envelope;
   logic       ir_tx_out;

   int checks = 0;
   int errors = 0;

   logic env_tr  [MAXS];
   logic out_tr  [MAXS];
   logic done_tr [MAXS];
   logic busy_tr [MAXS];
   int   n_tr;

   int run_val [200];
   int run_len [200];
   int n_runs;

   ir_nec_transmitter #(
      .UNIT_CYC     (10),
      .CARRIER_DIV  (6),
      .CARRIER_HIGH (2),
      .FRAME_UNITS  (192)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tx_start    (tx_start),
      .tx_repeat   (tx_repeat),
      .tx_addr     (tx_addr),
      .tx_cmd      (tx_cmd),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .ir_envelope (ir_envelope),
      .ir_tx_out   (ir_tx_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge right
   // after the accept edge, i.e. at sample 0 of the frame.
   task automatic start_frame(input logic s, input logic r);
      tx_start  = s;
      tx_repeat = r;
      @(posedge clk);
      @(negedge clk);
      tx_start  = 1'b0;
      tx_repeat = 1'b0;
   endtask

   // Record n samples; optionally pulse tx_start once at sample pulse_at.
   task automatic capture(input int n, input int pulse_at);
      n_tr = n;
      for (int i = 0; i < n; i++) begin
         env_tr[i]  = ir_envelope;
         out_tr[i]  = ir_tx_out;
         done_tr[i] = tx_done;
         busy_tr[i] = tx_busy;
         tx_start   = (i == pulse_at);
         @(negedge clk);
      end
      tx_start = 1'b0;
   endtask

   task automatic build_runs();
      n_runs = 0;
      for (int i = 0; i < n_tr; i++) begin
         if (i == 0 || env_tr[i] != env_tr[i-1]) begin
            if (n_runs < 200) begin
               run_val[n_runs] = int'(env_tr[i]);
               run_len[n_runs] = 1;
               n_runs++;
            end
         end else begin
            run_len[n_runs-1]++;
         end
      end
   endtask

   // Checks common to both frame types: done timing, busy window, carrier.
   task automatic common_checks(input string tag);
      int first_done;
      int n_done;
      int idle_bad;
      int car_bad;
      int ph;
      logic exp_out;
      first_done = -1;
      n_done = 0;
      idle_bad = 0;
      car_bad = 0;
      ph = 0;
      for (int i = 0; i < n_tr; i++) begin
         if (done_tr[i]) begin
            n_done++;
            if (first_done < 0) first_done = i;
         end
         if (i > 1920 && (env_tr[i] || busy_tr[i] || done_tr[i])) idle_bad++;
         if (env_tr[i]) begin
            if (i == 0 || !env_tr[i-1]) ph = 0;
            else ph++;
            exp_out = ((ph % 6) < 2);
         end else begin
            exp_out = 1'b0;
         end
         if (out_tr[i] !== exp_out) car_bad++;
      end
      check({tag, "_env_rise"}, 32'(env_tr[0]), 32'd1);
      check({tag, "_busy_rise"}, 32'(busy_tr[0]), 32'd1);
      check({tag, "_done_at"}, first_done, 32'd1920);
      check({tag, "_done_count"}, n_done, 32'd1);
      check({tag, "_busy_last"}, 32'(busy_tr[1919]), 32'd1);
      check({tag, "_busy_fall"}, 32'(busy_tr[1920]), 32'd0);
      check({tag, "_idle_after"}, idle_bad, 32'd0);
      check({tag, "_carrier"}, car_bad, 32'd0);
   endtask

   task automatic analyze_data(input string tag, input logic [31:0] exp_word);
      int bad;
      int fall;
      logic [31:0] word;
      build_runs();
      bad = 0;
      word = '0;
      for (int b = 0; b < 32; b++) begin
         if (run_len[2+2*b] != 10) bad++;
         if (run_len[3+2*b] == 30) word[b] = 1'b1;
         else if (run_len[3+2*b] != 10) bad++;
      end
      fall = 0;
      for (int r = 0; r < 67; r++) fall += run_len[r];
      check({tag, "_lead_mark"}, run_len[0], 32'd160);
      check({tag, "_lead_space"}, run_len[1], 32'd80);
      check({tag, "_bit_timing"}, bad, 32'd0);
      check({tag, "_word"}, word, exp_word);
      check({tag, "_stop_mark"}, run_len[66], 32'd10);
      check({tag, "_runs"}, n_runs, 32'd68);
      check({tag, "_env_fall"}, fall, 32'd1210);
      common_checks(tag);
   endtask

   task automatic analyze_repeat(input string tag);
      build_runs();
      check({tag, "_lead_mark"}, run_len[0], 32'd160);
      check({tag, "_rep_space"}, run_len[1], 32'd40);
      check({tag, "_stop_mark"}, run_len[2], 32'd10);
      check({tag, "_runs"}, n_runs, 32'd4);
      common_checks(tag);
   endtask

   initial begin
      int bad;

      rst_n     = 1'b0;
      tx_start  = 1'b0;
      tx_repeat = 1'b0;
      tx_addr   = 8'h00;
      tx_cmd    = 8'h00;
      repeat (3) @(negedge clk);

      check("reset_busy", 32'(tx_busy), 32'd0);
      check("reset_done", 32'(tx_done), 32'd0);
      check("reset_env", 32'(ir_envelope), 32'd0);
      check("reset_out", 32'(ir_tx_out), 32'd0);
      rst_n = 1'b1;

      // 1: idle after reset release
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (tx_busy || tx_done || ir_envelope || ir_tx_out) bad++;
      end
      check("t1_idle_outputs", bad, 32'd0);
      $display("t1 idle 1000 cycles checked");

      // 2: data frame addr=00 cmd=05 -> bytes 00,FF,05,FA
      tx_addr = 8'h00;
      tx_cmd  = 8'h05;
      start_frame(1'b1, 1'b0);
      capture(2200, -1);
      analyze_data("t2", 32'hFA05FF00);
      $display("t2 data frame addr=00 cmd=05 analysed");

      // 3: repeat frame
      start_frame(1'b0, 1'b1);
      capture(2200, -1);
      analyze_repeat("t3");
      $display("t3 repeat frame analysed");

      // 4: start+repeat together -> data frame; inputs changed and a
      //    tx_start pulse injected mid-frame must both be ignored
      tx_addr = 8'hA5;
      tx_cmd  = 8'h3C;
      start_frame(1'b1, 1'b1);
      tx_addr = 8'hFF;
      tx_cmd  = 8'hFF;
      capture(2400, 500);
      analyze_data("t4", 32'hC33C5AA5);
      $display("t4 start+repeat with mid-frame start analysed");

      // 6: reset during bit 10 mark (samples 480..489 for addr=00 cmd=05)
      tx_addr = 8'h00;
      tx_cmd  = 8'h05;
      start_frame(1'b1, 1'b0);
      repeat (485) @(negedge clk);
      check("t6_in_bit10_mark", 32'(ir_envelope), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t6_abort_env", 32'(ir_envelope), 32'd0);
      check("t6_abort_out", 32'(ir_tx_out), 32'd0);
      check("t6_abort_busy", 32'(tx_busy), 32'd0);
      check("t6_abort_done", 32'(tx_done), 32'd0);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (tx_done || tx_busy || ir_envelope) bad++;
      end
      check("t6_no_done_after_abort", bad, 32'd0);
      tx_addr = 8'h12;
      tx_cmd  = 8'h34;
      start_frame(1'b1, 1'b0);
      capture(2200, -1);
      analyze_data("t6", 32'hCB34ED12);
      $display("t6 abort and recovery frame addr=12 cmd=34 analysed");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
